// File: rtl/usart_recv_frame_pkg.sv
// Shared constants for the 5-byte status frame receiver.
// Holds the frame length, byte-FSM state encodings and header masks.
// Imported by the byte receiver, the frame assembler and the interface.
package usart_recv_frame_pkg;

  localparam int RX_NUM = 5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bits that must be zero in the address byte and in the mode byte.
  localparam logic [7:0] HDR0_MASK = 8'hFC;
  localparam logic [7:0] HDR1_MASK = 8'hC0;

endpackage

// File: rtl/usart_recv_frame_if.sv
// Serial line and decoded frame fields of the status frame receiver.
// master: the receiver (drives fields and pulses, reads the line).
// slave: the consumer / line driver.
interface usart_recv_frame_if;
  import usart_recv_frame_pkg::*;

  logic        uart_rxd;
  logic        received_done;
  logic [1:0]  Adress;
  logic [5:0]  Mod_SEL;
  logic [23:0] D;
  logic        frame_err;

  modport master (
    input  uart_rxd,
    output received_done, Adress, Mod_SEL, D, frame_err
  );

  modport slave (
    output uart_rxd,
    input  received_done, Adress, Mod_SEL, D, frame_err
  );

endinterface

// File: rtl/usart_recv_frame_uart_recv.sv
// 8N1 byte receiver: 2-FF synchronizer, falling-edge start detect, centre sampling.
// rx_byte_vld / rx_byte_err pulse combinationally in the stop-bit centre sample cycle.
// No backpressure: each byte is presented for one cycle only; rx_idle reports FSM idle.
module uart_recv
  import usart_recv_frame_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = 16'd434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       rx_byte_err,
  output logic       rx_idle
);

  localparam logic [15:0] HALF_LAST = BPS_CNT / 16'd2 - 16'd1;
  localparam logic [15:0] BIT_LAST  = BPS_CNT - 16'd1;

  logic      sync1, sync2, prev;
  logic      fall;
  rx_state_t state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        cnt_clr;
  logic        shift_en;

  assign fall    = !sync2 && prev;
  assign rx_idle = (state == RX_IDLE);

  // Line synchronizer plus history flop; preset high so reset looks like an idle line.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Byte FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= RX_IDLE;
    else         state <= state_nxt;
  end

  // Next state, counter control and byte result pulses.
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    shift_en    = 1'b0;
    rx_byte_vld = 1'b0;
    rx_byte_err = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          // A start bit that is already high again at its centre was a glitch.
          state_nxt = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr     = 1'b1;
          rx_byte_vld = sync2;
          rx_byte_err = !sync2;
          // Back to idle at mid-stop so an early next start edge is still seen.
          state_nxt   = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      rx_byte <= 8'd0;
    end else begin
      cnt <= cnt_clr ? 16'd0 : cnt + 16'd1;
      if (state == RX_IDLE) bit_idx <= 3'd0;
      else if (shift_en)    bit_idx <= bit_idx + 3'd1;
      if (shift_en) rx_byte <= {sync2, rx_byte[7:1]};
    end
  end

endmodule

// File: rtl/usart_recv_frame.sv
// Status frame receiver: assembles 5 bytes into Adress/Mod_SEL/D, publishes atomically.
// received_done pulses 1 cycle after the stop-bit centre sample of byte 5.
// No backpressure: a frame is aborted (frame_err) on stop, header or inter-byte gap error.
module usart_recv_frame
  import usart_recv_frame_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = 16'd434
) (
  input  logic sys_clk,
  input  logic sys_rst,
  usart_recv_frame_if.master bus
);

  localparam logic [31:0] GAP_CNT  = 32'(BPS_CNT) * 32'd20;
  localparam logic [2:0]  IDX_LAST = 3'(RX_NUM - 1);

  logic [7:0]  rx_byte;
  logic        rx_byte_vld;
  logic        rx_byte_err;
  logic        rx_idle;

  logic [2:0]  idx;
  logic [31:0] gap_cnt;
  // Bytes 1..4 are staged; byte 5 is taken straight from the receiver on publish.
  logic [7:0]  stage [0:RX_NUM-2];
  logic        hdr_bad;

  logic        received_done;
  logic        frame_err;
  logic [1:0]  adress;
  logic [5:0]  mod_sel;
  logic [23:0] d;

  uart_recv #(.BPS_CNT(BPS_CNT)) u_recv (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_rxd    (bus.uart_rxd),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .rx_byte_err (rx_byte_err),
    .rx_idle     (rx_idle)
  );

  // Header bytes carry reserved zero bits; anything else there means framing is lost.
  always_comb begin
    hdr_bad = 1'b0;
    if (idx == 3'd0 && (rx_byte & HDR0_MASK) != 8'd0) hdr_bad = 1'b1;
    if (idx == 3'd1 && (rx_byte & HDR1_MASK) != 8'd0) hdr_bad = 1'b1;
  end

  // Frame assembly, gap timer and output registers; byte_vld outranks gap expiry.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx           <= 3'd0;
      gap_cnt       <= 32'd0;
      received_done <= 1'b0;
      frame_err     <= 1'b0;
      adress        <= 2'd0;
      mod_sel       <= 6'd0;
      d             <= 24'd0;
      for (int i = 0; i < RX_NUM - 1; i++) stage[i] <= 8'd0;
    end else begin
      received_done <= 1'b0;
      frame_err     <= 1'b0;
      if (rx_byte_vld) begin
        gap_cnt <= 32'd0;
        if (hdr_bad) begin
          idx       <= 3'd0;
          frame_err <= 1'b1;
        end else if (idx == IDX_LAST) begin
          idx           <= 3'd0;
          received_done <= 1'b1;
          adress        <= stage[0][1:0];
          mod_sel       <= stage[1][5:0];
          d             <= {stage[2], stage[3], rx_byte};
        end else begin
          stage[idx[1:0]] <= rx_byte;
          idx             <= idx + 3'd1;
        end
      end else if (rx_byte_err) begin
        idx       <= 3'd0;
        frame_err <= 1'b1;
        gap_cnt   <= 32'd0;
      end else if (idx != 3'd0 && rx_idle) begin
        if (gap_cnt == GAP_CNT - 32'd1) begin
          idx       <= 3'd0;
          frame_err <= 1'b1;
          gap_cnt   <= 32'd0;
        end else begin
          gap_cnt <= gap_cnt + 32'd1;
        end
      end else begin
        gap_cnt <= 32'd0;
      end
    end
  end

  assign bus.received_done = received_done;
  assign bus.frame_err     = frame_err;
  assign bus.Adress        = adress;
  assign bus.Mod_SEL       = mod_sel;
  assign bus.D             = d;

endmodule

// File: tb/tb_usart_recv_frame.sv
// Directed bench for usart_recv_frame: bit-level serial driver, pulse counters, field checks.
// Bit period is shortened to keep runtime small; glitch length is scaled to stay below half a bit.
module tb_usart_recv_frame;
  import usart_recv_frame_pkg::*;

  localparam int BPS = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   done_cnt;
  int   err_cnt;
  int   both_cnt;
  int   done_base;
  int   err_base;

  usart_recv_frame_if rx_if ();

  usart_recv_frame #(.BPS_CNT(16'(BPS))) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_if.received_done) done_cnt++;
    if (rx_if.frame_err) err_cnt++;
    if (rx_if.received_done && rx_if.frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_if.uart_rxd = v;
    repeat (BPS) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    send_byte(b4, 1'b1);
  endtask

  task automatic mark;
    done_base = done_cnt;
    err_base  = err_cnt;
  endtask

  task automatic check_fields(input string tag, input logic [1:0] a, input logic [5:0] m,
                              input logic [23:0] dv);
    @(negedge clk);
    check({tag, ".adress"}, 32'(rx_if.Adress), 32'(a));
    check({tag, ".mod_sel"}, 32'(rx_if.Mod_SEL), 32'(m));
    check({tag, ".d"}, 32'(rx_if.D), 32'(dv));
  endtask

  // Hard watchdog so the run always ends.
  initial begin
    #(4_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    rx_if.uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst.done", 32'(rx_if.received_done), 32'd0);
    check("rst.err", 32'(rx_if.frame_err), 32'd0);
    check_fields("rst", 2'd0, 6'd0, 24'd0);
    rst = 1'b0;
    repeat (3 * BPS) @(posedge clk);

    // 1: clean frame; done must already be seen by the end of byte 5's stop bit.
    mark();
    send_frame(8'h02, 8'h2A, 8'h12, 8'h34, 8'h56);
    check("t1.done", 32'(done_cnt - done_base), 32'd1);
    check("t1.err", 32'(err_cnt - err_base), 32'd0);
    check_fields("t1", 2'b10, 6'h2A, 24'h123456);

    // 2: bad stop on byte 3. The low stop merges with byte 4 (no new edge),
    //    so A5 arrives as a fresh first byte and fails the header check too.
    repeat (2 * BPS) @(posedge clk);
    mark();
    send_byte(8'h01, 1'b1);
    send_byte(8'h3F, 1'b1);
    send_byte(8'hFF, 1'b0);
    check("t2.err_stop3", 32'(err_cnt - err_base), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1);
    drive_bit(1'b1);
    check("t2.err_total", 32'(err_cnt - err_base), 32'd2);
    check("t2.done", 32'(done_cnt - done_base), 32'd0);
    check_fields("t2.hold", 2'b10, 6'h2A, 24'h123456);
    mark();
    send_frame(8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    check("t2.done_next", 32'(done_cnt - done_base), 32'd1);
    check_fields("t2.next", 2'd3, 6'h01, 24'h000001);

    // 3: bad first-byte header, then a clean frame right behind it.
    mark();
    send_byte(8'h05, 1'b1);
    check("t3.err", 32'(err_cnt - err_base), 32'd1);
    send_frame(8'h01, 8'h15, 8'hAB, 8'hCD, 8'hEF);
    check("t3.done", 32'(done_cnt - done_base), 32'd1);
    check("t3.err_only1", 32'(err_cnt - err_base), 32'd1);
    check_fields("t3", 2'd1, 6'h15, 24'hABCDEF);

    // 4: three bytes then a long idle hits the gap limit.
    mark();
    send_byte(8'h02, 1'b1);
    send_byte(8'h3F, 1'b1);
    send_byte(8'h11, 1'b1);
    check("t4.no_err_yet", 32'(err_cnt - err_base), 32'd0);
    repeat (25 * BPS) @(posedge clk);
    check("t4.gap_err", 32'(err_cnt - err_base), 32'd1);
    check("t4.no_done", 32'(done_cnt - done_base), 32'd0);
    mark();
    send_frame(8'h00, 8'h3F, 8'hFF, 8'hFF, 8'hFF);
    check("t4.done", 32'(done_cnt - done_base), 32'd1);
    check_fields("t4", 2'd0, 6'h3F, 24'hFFFFFF);

    // 5: short low glitch on the idle line is ignored.
    mark();
    rx_if.uart_rxd = 1'b0;
    repeat (BPS / 2 - 4) @(posedge clk);
    rx_if.uart_rxd = 1'b1;
    repeat (20 * BPS) @(posedge clk);
    check("t5.err", 32'(err_cnt - err_base), 32'd0);
    check("t5.done", 32'(done_cnt - done_base), 32'd0);
    send_frame(8'h02, 8'h00, 8'h5A, 8'h5A, 8'h5A);
    check("t5.done_after", 32'(done_cnt - done_base), 32'd1);
    check_fields("t5", 2'd2, 6'h00, 24'h5A5A5A);

    // 6: reset during byte 4 clears outputs at once; the tail makes no frame.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h34 >> i));
    rst = 1'b1;
    #1;
    check("t6.rst_adress", 32'(rx_if.Adress), 32'd0);
    check("t6.rst_mod", 32'(rx_if.Mod_SEL), 32'd0);
    check("t6.rst_d", 32'(rx_if.D), 32'd0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    mark();
    for (int i = 4; i < 8; i++) drive_bit(1'(8'h34 >> i));
    drive_bit(1'b1);
    send_byte(8'h04, 1'b1);
    repeat (25 * BPS) @(posedge clk);
    check("t6.no_done", 32'(done_cnt - done_base), 32'd0);
    mark();
    send_frame(8'h01, 8'h2B, 8'h9A, 8'hBC, 8'hDE);
    check("t6.done", 32'(done_cnt - done_base), 32'd1);
    check_fields("t6", 2'd1, 6'h2B, 24'h9ABCDE);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
